// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling UART receiver with 3-sample majority vote
module uart_rx_os16 #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 rx_clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] received,
  output logic                 rx_drdy,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int HOLD_W = $clog2(OVERSAMPLE + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVERSAMPLE);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TICK_W-1:0]    tick;
  logic [IDX_W-1:0]     index;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 samp0;
  logic                 samp1;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 majority;
  logic                 at_vote;
  logic                 at_last;
  logic                 frame_ok;
  logic                 frame_bad;

  // Samples from ticks 7 and 8 are registered; the tick-9 sample is live rx_s.
  assign majority  = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign at_vote   = (tick == TICK_S2);
  assign at_last   = (tick == TICK_LAST);
  assign frame_ok  = (state == STOP) && at_vote && majority;
  assign frame_bad = (state == STOP) && at_vote && !majority;

  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: begin
        if (at_vote && majority) state_next = IDLE;
        else if (at_last)        state_next = DATA;
      end
      DATA:  if (at_last && index == IDX_LAST) state_next = STOP;
      STOP:  if (at_vote) state_next = majority ? IDLE : BREAK;
      BREAK: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      tick      <= '0;
      index     <= '0;
      shift_reg <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
    end else begin
      if (state_next != state || state == IDLE || state == BREAK || at_last) tick <= '0;
      else                                                                   tick <= tick + 1'b1;
      if (tick == TICK_S0) samp0 <= rx_s;
      if (tick == TICK_S1) samp1 <= rx_s;
      if (state != DATA)   index <= '0;
      else if (at_last)    index <= index + 1'b1;
      if (state == DATA && at_vote) shift_reg[index] <= majority;
    end
  end

  // The hold counter is free of the FSM so a new frame can restart the drdy window.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      received  <= '0;
      rx_drdy   <= 1'b0;
      frame_err <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      frame_err <= frame_bad;
      if (frame_ok) begin
        received <= shift_reg;
        rx_drdy  <= 1'b1;
        hold_cnt <= HOLD_LOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HOLD_ONE) rx_drdy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 Parameters SHALL be: OVERSAMPLE, 16, rx_clk cycles per bit; DATA_BITS, 8, data bits per frame, LSB first.
REQ-002 Port: rx_clk  input  1  sample clock, 16x baud (153600 Hz for 9600 baud); all state is updated on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: rx  input  1  asynchronous serial line; idles high.
REQ-005 Port: received  output  8  last correctly framed byte.
REQ-006 Port: rx_drdy  output  1  data-ready level; the consumer detects its rising edge.
REQ-007 Port: frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer, reset value 1; the result is rx_s, and all logic below uses only rx_s.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-011 A tick counter SHALL run 0..OVERSAMPLE-1 per bit, reset to 0 on every state entry, and wrap 15->0 at each bit boundary.
REQ-012 Bit value SHALL be the majority of rx_s sampled at ticks 7, 8 and 9, decided at tick 9.
REQ-013 IDLE: when rx_s==0, go to START with tick=0 on the next cycle; define t0 as the first START cycle.
REQ-014 START: a majority of 1 is a false start; go to IDLE on the next cycle, with no output change.
REQ-015 START: a majority of 0 continues to tick 15, then enters DATA with bit index 0.
REQ-016 DATA: at tick 9, shift the majority into shift register bit [index], LSB first.
REQ-017 DATA: after index DATA_BITS-1 reaches tick 15, go to STOP.
REQ-018 STOP at tick 9, majority 1:
- received <= shift register.
- rx_drdy <= 1.
- Go to IDLE on the next cycle, without waiting for the end of the stop bit.
REQ-019 STOP at tick 9, majority 0:
- frame_err is high for exactly one cycle.
- received and rx_drdy are unchanged.
- Go to BREAK.
REQ-020 BREAK SHALL wait until rx_s==1, then go to IDLE; a line held low SHALL never retrigger START.
REQ-021 Latency: received and rx_drdy SHALL update at edge t0+154 (stop tick 9 = t0+153, registered one cycle later).
REQ-022 The rx_drdy hold counter:
- Holds rx_drdy high for exactly OVERSAMPLE cycles, then drives it low.
- Is independent of the FSM.
- Is restarted (not extended beyond 16 cycles from the new load) by a new load while high.
REQ-023 received SHALL hold its value until the next valid frame; it is never cleared except by reset.
REQ-024 Back-to-back frames SHALL be accepted: a start edge seen in IDLE immediately after STOP is valid.
REQ-025 busy SHALL be combinational from state: 0 in IDLE, 1 otherwise.

Reset
REQ-026 With reset low, the outputs and registers SHALL be:
- received = 8'h00
- rx_drdy = 0
- frame_err = 0
- busy = 0
- state = IDLE
- tick, index and shift register = 0
- hold counter = 0
- synchronizer flops = 1
REQ-027 Reset asserted mid-frame SHALL abort immediately with no rx_drdy or frame_err pulse; after release, reception restarts only on a new falling edge.
REQ-028 No output SHALL glitch on reset release; the first FSM transition is no earlier than the first rx_clk edge after release.

Verification
REQ-029 Frame 0x41 ('A') at exactly 16 cycles/bit -> received=0x41 at t0+154, rx_drdy high for 16 cycles, frame_err=0 throughout.
REQ-030 rx low-glitch of 4 cycles, line otherwise idle -> START entered then aborted at tick 9, busy returns to 0, received/rx_drdy unchanged.
REQ-031 Frame 0x52 with stop bit low and line held low for 40 further bit-times -> one frame_err pulse, received keeps its prior value, FSM stays in BREAK until rx high, then a frame 0x5A decodes correctly.
REQ-032 Back-to-back frames 0x52 then 0x00 with no idle gap -> two rx_drdy rising edges, received=0x52 then 0x00.
REQ-033 Reset pulsed low during DATA bit 3 of 0xFF -> all outputs at reset values, no rx_drdy; the next clean frame 0x43 decodes correctly.
REQ-034 Frame 0x55 with bit period 15 and then 17 cycles (±6%) -> received=0x55 both times, no frame_err.
